// File: rtl/clock_time_source.sv
// MM:SS time-keeping and digit-scan source for the segment display driver.
// A prescaler produces the 1 s tick; a separate free-running divider advances the scan phase.
module clock_time_source #(
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 10_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        set_sec,
  input  logic        set_min,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic        sec_tick,
  output logic        hour_wrap
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0]  pre_cnt, pre_nxt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [5:0]        sec_val, min_val, sec_nxt, min_nxt;
  logic              tick, carry, wrap_nxt;

  // Modulo-60 increment; anything at or above 59 folds back to zero.
  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    tick    = run && (pre_cnt == PRE_LAST);
    pre_nxt = pre_cnt;
    if (run)
      pre_nxt = tick ? '0 : pre_cnt + PRE_W'(1);
    // A set_sec pulse replaces the tick's seconds increment, so its carry is dropped.
    carry   = tick && !set_sec && (sec_val == 6'd59);
    sec_nxt = sec_val;
    if (set_sec || tick)
      sec_nxt = inc_mod60(sec_val);
    min_nxt = min_val;
    if (set_min || carry)
      min_nxt = inc_mod60(min_val);
    wrap_nxt = carry && !set_min && (min_val == 6'd59);
  end

  // Time-keeping registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt   <= '0;
      sec_val   <= '0;
      min_val   <= '0;
      sec_tick  <= 1'b0;
      hour_wrap <= 1'b0;
    end else if (clear) begin
      pre_cnt   <= '0;
      sec_val   <= '0;
      min_val   <= '0;
      sec_tick  <= 1'b0;
      hour_wrap <= 1'b0;
    end else begin
      pre_cnt   <= pre_nxt;
      sec_val   <= sec_nxt;
      min_val   <= min_nxt;
      sec_tick  <= tick;
      hour_wrap <= wrap_nxt;
    end
  end

  // Scan phase: free-running, ignores run and clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      byte_status <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt    <= '0;
      byte_status <= byte_status + 3'd1;
    end else begin
      scan_cnt    <= scan_cnt + SCAN_W'(1);
    end
  end

  assign data_show = {min_val, sec_val};

endmodule

// File: tb/tb_clock_time_source.sv
// Directed bench for clock_time_source; a whole-seconds time model checks every cycle.
module tb_clock_time_source;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, clear = 1'b0, set_sec = 1'b0, set_min = 1'b0;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic        sec_tick, hour_wrap;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: time as total seconds in the hour, scan as cycles since reset
  int m_t = 0, m_pre = 0, m_cyc = 0;
  bit m_tick = 1'b0, m_wrap = 1'b0;
  int ms, mm;
  bit mt;

  clock_time_source #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset(reset), .run(run), .clear(clear),
    .set_sec(set_sec), .set_min(set_min), .data_show(data_show),
    .byte_status(byte_status), .sec_tick(sec_tick), .hour_wrap(hour_wrap)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_t = 0; m_pre = 0; m_cyc = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_cyc++;
      if (clear) begin
        m_t = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
      end else begin
        mt = run && (m_pre == TICK_DIV - 1);
        if (run) m_pre = (m_pre + 1) % TICK_DIV;
        ms = m_t % 60;
        mm = m_t / 60;
        m_wrap = 0;
        if (mt && !set_sec && !set_min) begin
          m_wrap = (m_t == 3599);
          m_t = (m_t + 1) % 3600;
        end else begin
          if (set_sec || mt) ms = (ms + 1) % 60;
          if (set_min || (mt && !set_sec && (m_t % 60) == 59)) mm = (mm + 1) % 60;
          m_t = mm * 60 + ms;
        end
        m_tick = mt;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("data_show", 32'(data_show), 32'(((m_t / 60) << 6) | (m_t % 60)));
      chk("byte_status", 32'(byte_status), 32'((m_cyc / SCAN_DIV) % 8));
      chk("sec_tick", 32'(sec_tick), 32'(m_tick));
      chk("hour_wrap", 32'(hour_wrap), 32'(m_wrap));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  logic [2:0] exp5 [24] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                             3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5,
                             3'd5, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0};

  initial begin
    step(2);
    chk_en = 1'b1;
    chk("rst_data", 32'(data_show), 32'h0);
    chk("rst_scan", 32'(byte_status), 32'h0);
    reset = 1'b0;

    // 1: first tick after four run cycles
    run = 1'b1;
    step(3);
    chk("t1_no_tick_yet", 32'(sec_tick), 32'h0);
    step(1);
    chk("t1_tick", 32'(sec_tick), 32'h1);
    chk("t1_data", 32'(data_show), 32'h001);

    // 2: run 8 total then freeze
    step(4);
    chk("t2_data_run", 32'(data_show), 32'h002);
    run = 1'b0;
    step(20);
    chk("t2_data_frozen", 32'(data_show), 32'h002);
    chk("t2_no_tick", 32'(sec_tick), 32'h0);

    // 3: 59:59 then roll over
    do_reset();
    set_min = 1'b1; step(59); set_min = 1'b0;
    set_sec = 1'b1; step(59); set_sec = 1'b0;
    chk("t3_preset", 32'(data_show), 32'hEFB);
    run = 1'b1;
    step(4);
    run = 1'b0;
    chk("t3_data", 32'(data_show), 32'h000);
    chk("t3_tick", 32'(sec_tick), 32'h1);
    chk("t3_wrap", 32'(hour_wrap), 32'h1);

    // 4: set_sec coinciding with terminal count at 03:59
    do_reset();
    set_min = 1'b1; step(3); set_min = 1'b0;
    set_sec = 1'b1; step(59); set_sec = 1'b0;
    chk("t4_preset", 32'(data_show), 32'h0FB);
    run = 1'b1;
    step(3);
    set_sec = 1'b1;
    step(1);
    set_sec = 1'b0;
    run = 1'b0;
    chk("t4_data", 32'(data_show), 32'h0C0);
    chk("t4_tick", 32'(sec_tick), 32'h1);
    chk("t4_wrap", 32'(hour_wrap), 32'h0);

    // 5: scan sequence with clear and run toggles
    do_reset();
    for (int k = 0; k < 24; k++) begin
      clear = (k == 4);
      run = (k >= 8 && k < 13);
      step(1);
      chk("t5_scan", 32'(byte_status), 32'(exp5[k]));
    end
    clear = 1'b0;
    run = 1'b0;

    // 6: async reset mid-count, then recover and clear
    do_reset();
    run = 1'b1;
    step(22);
    run = 1'b0;
    step(17);
    chk("t6_pre_data", 32'(data_show), 32'h005);
    chk("t6_pre_scan", 32'(byte_status), 32'h5);
    reset = 1'b1;
    #1;
    chk("t6_async_data", 32'(data_show), 32'h0);
    chk("t6_async_scan", 32'(byte_status), 32'h0);
    chk("t6_async_tick", 32'(sec_tick), 32'h0);
    chk("t6_async_wrap", 32'(hour_wrap), 32'h0);
    step(1);
    reset = 1'b0;
    run = 1'b1;
    step(4);
    chk("t6_resume", 32'(data_show), 32'h001);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b0;
    chk("t6_clear", 32'(data_show), 32'h000);
    chk("t6_clear_tick", 32'(sec_tick), 32'h0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
